// File: rtl/spi_regmap_pkg.sv
// Register map, frame geometry and FSM encoding shared by the SPI register file,
// pwm_peripheral and the bench.
package spi_regmap_pkg;

  localparam int FRAME_BITS = 16;
  localparam int NUM_REGS   = 5;
  localparam int ADDR_W     = 7;
  localparam int DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } spi_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchronizer for one asynchronous pin, plus a history flop that
// turns the synchronized level into single-cycle rise/fall strobes.
module sync_edge_detect #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: non-blocking assignments make every stage sample the previous stage's
  // old value; blocking here would collapse the chain into a single flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= {SYNC_STAGES{RESET_VAL}};
      r_prev <= RESET_VAL;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], din};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign sync = r_sync[SYNC_STAGES-1];
  assign rise = r_sync[SYNC_STAGES-1] & ~r_prev;
  assign fall = ~r_sync[SYNC_STAGES-1] & r_prev;

endmodule

// File: rtl/spi_peripheral.sv
// Write-only SPI (mode 0) register file feeding pwm_peripheral: each valid
// 16-bit write frame updates one of five 8-bit control registers.
module spi_peripheral
  import spi_regmap_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       frame_commit
);

  localparam int                CNT_W    = $clog2(FRAME_BITS + 2);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(FRAME_BITS + 1);

  logic w_sclk_sync, w_sclk_rise, w_sclk_fall_unused;
  logic w_ncs_sync_unused, w_ncs_rise, w_ncs_fall;
  logic w_copi_sync, w_copi_rise_unused, w_copi_fall_unused;

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (sclk),
    .sync (w_sclk_sync),
    .rise (w_sclk_rise),
    .fall (w_sclk_fall_unused)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (ncs),
    .sync (w_ncs_sync_unused),
    .rise (w_ncs_rise),
    .fall (w_ncs_fall)
  );

  sync_edge_detect #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_copi (
    .clk  (clk),
    .rst_n(rst_n),
    .din  (copi),
    .sync (w_copi_sync),
    .rise (w_copi_rise_unused),
    .fall (w_copi_fall_unused)
  );

  spi_state_e              r_state;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [CNT_W-1:0]        r_bit_cnt;
  logic                    r_commit;
  logic [NUM_REGS-1:0][7:0] r_regs;

  logic              w_rw;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic              w_write_ok;

  assign w_rw   = r_shift[FRAME_BITS-1];
  assign w_addr = r_shift[FRAME_BITS-2 -: ADDR_W];
  assign w_data = r_shift[DATA_W-1:0];

  // Short frames and overlong frames (counter parked at FRAME_BITS+1) both fail.
  assign w_write_ok = (r_bit_cnt == CNT_FULL) && w_rw &&
                      (w_addr < ADDR_W'(NUM_REGS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_commit  <= 1'b0;
      // NOTE: the register bank is plain flops, not RAM, so it is reset
      // explicitly; pwm_peripheral must see all outputs disabled out of reset.
      r_regs    <= '0;
    end else begin
      // NOTE: default-low every cycle so the commit strobe is exactly one clk wide.
      r_commit <= 1'b0;
      unique case (r_state)
        ST_IDLE: begin
          if (w_ncs_fall) begin
            r_state   <= ST_SHIFT;
            r_shift   <= '0;
            r_bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          // End of frame takes priority over a coincident SCLK edge.
          if (w_ncs_rise) begin
            r_state <= ST_COMMIT;
          end else if (w_sclk_rise) begin
            r_shift <= {r_shift[FRAME_BITS-2:0], w_copi_sync};
            if (r_bit_cnt != CNT_MAX) r_bit_cnt <= r_bit_cnt + 1'b1;
          end
        end
        ST_COMMIT: begin
          r_state <= ST_IDLE;
          if (w_write_ok) begin
            r_commit <= 1'b1;
            case (w_addr)
              ADDR_EN_OUT_7_0:  r_regs[0] <= w_data;
              ADDR_EN_OUT_15_8: r_regs[1] <= w_data;
              ADDR_EN_PWM_7_0:  r_regs[2] <= w_data;
              ADDR_EN_PWM_15_8: r_regs[3] <= w_data;
              ADDR_PWM_DUTY:    r_regs[4] <= w_data;
              default: ;
            endcase
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign en_reg_out_7_0  = r_regs[0];
  assign en_reg_out_15_8 = r_regs[1];
  assign en_reg_pwm_7_0  = r_regs[2];
  assign en_reg_pwm_15_8 = r_regs[3];
  assign pwm_duty_cycle  = r_regs[4];
  assign frame_commit    = r_commit;

endmodule

// File: tb/tb_spi_peripheral.sv
// Scoreboard bench for spi_peripheral: frames push expected register snapshots,
// a monitor pops and compares on every frame_commit pulse.
module tb_spi_peripheral;
  import spi_regmap_pkg::*;

  localparam int SYNC_STAGES = 2;
  localparam int HALF_SCLK   = 50;  // clk cycles per SCLK phase (10 MHz / 100 kHz)

  typedef logic [NUM_REGS-1:0][7:0] regs_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic sclk  = 1'b0;
  logic copi  = 1'b0;
  logic ncs   = 1'b1;
  logic [7:0] en_reg_out_7_0, en_reg_out_15_8, en_reg_pwm_7_0, en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       frame_commit;

  int    n_checks  = 0;
  int    n_fail    = 0;
  int    n_commits = 0;
  int    n_posedge = 0;
  int    rise_at   = 0;
  int    c0;
  regs_t exp_regs  = '0;
  regs_t sb_q[$];
  regs_t dut_regs;

  spi_peripheral #(.SYNC_STAGES(SYNC_STAGES)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .sclk           (sclk),
    .copi           (copi),
    .ncs            (ncs),
    .en_reg_out_7_0 (en_reg_out_7_0),
    .en_reg_out_15_8(en_reg_out_15_8),
    .en_reg_pwm_7_0 (en_reg_pwm_7_0),
    .en_reg_pwm_15_8(en_reg_pwm_15_8),
    .pwm_duty_cycle (pwm_duty_cycle),
    .frame_commit   (frame_commit)
  );

  assign dut_regs = {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0,
                     en_reg_out_15_8, en_reg_out_7_0};

  always #50ns clk = ~clk;
  always @(posedge clk) n_posedge++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b);
    copi = b;
    wait_clk(HALF_SCLK);
    sclk = 1'b1;
    wait_clk(HALF_SCLK);
    sclk = 1'b0;
  endtask

  task automatic ncs_high();
    ncs     = 1'b1;
    rise_at = n_posedge;
  endtask

  task automatic send_frame(input logic [31:0] bits, input int nbits,
                            input bit wr, input int addr, input logic [7:0] data);
    ncs = 1'b0;
    wait_clk(HALF_SCLK);
    for (int i = 0; i < nbits; i++) spi_bit(bits[nbits-1-i]);
    wait_clk(HALF_SCLK);
    if (wr) begin
      exp_regs[addr] = data;
      sb_q.push_back(exp_regs);
    end
    ncs_high();
  endtask

  task automatic check_regs(input string tag);
    for (int i = 0; i < NUM_REGS; i++)
      check($sformatf("%s_reg%0d", tag, i), 32'(dut_regs[i]), 32'(exp_regs[i]));
  endtask

  task automatic drain(input string tag);
    int k = 0;
    while (sb_q.size() != 0 && k < 60) begin
      wait_clk(1);
      k++;
    end
    wait_clk(5);
    check({tag, "_drain"}, 32'(sb_q.size()), 0);
    check_regs(tag);
  endtask

  // Monitor: every commit pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    regs_t e;
    if (rst_n && frame_commit) begin
      n_commits++;
      check("sb_nonempty", 32'(sb_q.size() != 0), 1);
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        check("commit_latency", 32'(n_posedge - rise_at), SYNC_STAGES + 2);
        for (int i = 0; i < NUM_REGS; i++)
          check($sformatf("commit_reg%0d", i), 32'(dut_regs[i]), 32'(e[i]));
      end
    end
  end

  initial begin : watchdog
    #10ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    wait_clk(5);
    check("rst_commit_in_reset", 32'(frame_commit), 0);
    check_regs("rst_in_reset");
    rst_n = 1'b1;
    wait_clk(5);
    check("rst_commit", 32'(frame_commit), 0);
    check_regs("rst");

    // 1: single write to en_reg_out_7_0
    c0 = n_commits;
    send_frame(32'h80F0, 16, 1, 0, 8'hF0);
    drain("t1");
    check("t1_commits", 32'(n_commits - c0), 1);

    // 2: duty cycle written twice
    send_frame(32'h8480, 16, 1, 4, 8'h80);
    drain("t2a");
    send_frame(32'h84FF, 16, 1, 4, 8'hFF);
    drain("t2b");

    // 3: read frame and out-of-range address are discarded
    c0 = n_commits;
    send_frame(32'h0055, 16, 0, 0, 8'h00);
    send_frame(32'hB055, 16, 0, 0, 8'h00);
    drain("t3");
    check("t3_commits", 32'(n_commits - c0), 0);

    // 4: valid write, then a 12-bit and a 20-bit frame that must be dropped
    c0 = n_commits;
    send_frame(32'h81AA, 16, 1, 1, 8'hAA);
    drain("t4a");
    send_frame(32'h825, 12, 0, 0, 8'h00);
    send_frame(32'h8233A, 20, 0, 0, 8'h00);
    drain("t4b");
    check("t4_commits", 32'(n_commits - c0), 1);

    // 5: back-to-back frames with a 3-clk nCS high gap
    c0 = n_commits;
    send_frame(32'h8201, 16, 1, 2, 8'h01);
    wait_clk(3);
    send_frame(32'h8302, 16, 1, 3, 8'h02);
    drain("t5");
    check("t5_commits", 32'(n_commits - c0), 2);

    // 6: reset after bit 9 of 0x8077, then a clean 0x8011 frame
    c0 = n_commits;
    ncs = 1'b0;
    wait_clk(HALF_SCLK);
    for (int i = 15; i >= 7; i--) spi_bit(1'((16'h8077 >> i) & 16'h1));
    rst_n    = 1'b0;
    exp_regs = '0;
    wait_clk(3);
    check_regs("t6_in_reset");
    rst_n = 1'b1;
    wait_clk(3);
    for (int i = 6; i >= 0; i--) spi_bit(1'((16'h8077 >> i) & 16'h1));
    wait_clk(HALF_SCLK);
    ncs_high();
    drain("t6_abort");
    check("t6_abort_commits", 32'(n_commits - c0), 0);
    send_frame(32'h8011, 16, 1, 0, 8'h11);
    drain("t6");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
